// File: rtl/boot_pkg.sv
`default_nettype none
// boot_pkg: shared state encoding, LED bit positions and header byte order for boot_sequencer.
// Rev 1.0
package boot_pkg;

  typedef enum logic [2:0] {
    S_INITIAL,
    S_LEN,
    S_LOAD,
`ifdef BOOT_CHECKSUM_EN
    S_CSUM,
`endif
    S_READY,
    S_EXEC,
    S_HALT,
    S_ERROR
  } boot_state_t;

  localparam int LED_LOADED = 0;
  localparam int LED_EXEC   = 1;
  localparam int LED_HALTED = 2;
  localparam int LED_ERROR  = 3;

  // Header and program words arrive most-significant byte first.
  localparam bit HDR_MSB_FIRST = 1'b1;

  function automatic logic [3:0] led_onehot(input int idx);
    return 4'b0001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// byte_assembler: packs UART bytes into WORD_W words and pulses word_valid the cycle after the last byte.
// Rev 1.0
module byte_assembler #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);
  import boot_pkg::*;

  localparam int NB    = WORD_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (en && byte_valid) begin
        word <= HDR_MSB_FIRST ? ((word << 8) | WORD_W'(byte_in))
                              : ((word >> 8) | (WORD_W'(byte_in) << (WORD_W - 8)));
        if (r_cnt == LAST) begin
          r_cnt      <= '0;
          word_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/boot_sequencer.sv
`default_nettype none
// boot_sequencer: loads a length-prefixed UART image into instruction memory and sequences core reset/run/halt.
// Rev 1.0 -- define BOOT_CHECKSUM_EN to require a trailing XOR checksum word after the program.
module boot_sequencer #(
  parameter int WORD_W        = 32,
  parameter int MEM_INST_SIZE = 1024,
  parameter int MEM_SIZE      = 1024,
  parameter int AUTO_START    = 0
) (
  input  logic                             CLK,
  input  logic                             INITIALIZE,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  input  logic                             START_EXEC,
  input  logic                             RESTART_EXEC,
  input  logic                             core_halt,
  output logic                             imem_we,
  output logic [$clog2(MEM_INST_SIZE)-1:0] imem_addr,
  output logic [WORD_W-1:0]                imem_wdata,
  output logic [$clog2(MEM_INST_SIZE):0]   prog_words,
  output logic [WORD_W-1:0]                sp_init,
  output logic                             core_rst,
  output logic                             core_run,
  output logic [3:0]                       LED
);
  import boot_pkg::*;

  localparam int AW = $clog2(MEM_INST_SIZE);
  localparam logic [WORD_W-1:0] MAX_N = WORD_W'(MEM_INST_SIZE);

  boot_state_t       r_state;
  logic              r_restart;
  logic [AW-1:0]     r_idx;
  logic [AW:0]       r_n;
  logic [AW:0]       r_pw;
  logic              r_core_rst;
  logic              r_core_run;
  logic [3:0]        r_led;
  logic [WORD_W-1:0] w_word;
  logic              w_word_valid;
  logic              w_asm_en;
  logic              w_last_word;
`ifdef BOOT_CHECKSUM_EN
  logic [WORD_W-1:0] r_csum;
`endif

`ifdef BOOT_CHECKSUM_EN
  assign w_asm_en = (r_state == S_LEN) || (r_state == S_LOAD) || (r_state == S_CSUM);
`else
  assign w_asm_en = (r_state == S_LEN) || (r_state == S_LOAD);
`endif

  byte_assembler #(.WORD_W(WORD_W)) u_asm (
    .clk        (CLK),
    .rst        (INITIALIZE),
    .en         (w_asm_en),
    .byte_in    (rx_data),
    .byte_valid (rx_valid),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  assign w_last_word = ({1'b0, r_idx} == (r_n - 1'b1));

  // The write strobe is the assembler's registered word_valid, so it lands one cycle after the last byte.
  assign imem_we    = (r_state == S_LOAD) && w_word_valid;
  assign imem_addr  = r_idx;
  assign imem_wdata = w_word;
  assign prog_words = r_pw;
  assign sp_init    = WORD_W'(MEM_SIZE / 2);
  assign core_rst   = r_core_rst;
  assign core_run   = r_core_run;
  assign LED        = r_led;

  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      r_state    <= S_INITIAL;
      r_restart  <= 1'b0;
      r_idx      <= '0;
      r_n        <= '0;
      r_pw       <= '0;
      r_core_rst <= 1'b1;
      r_core_run <= 1'b0;
      r_led      <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        S_INITIAL: r_state <= S_LEN;
        S_LEN: if (w_word_valid) begin
          r_n <= w_word[AW:0];
          if (w_word > MAX_N) begin
            r_state <= S_ERROR;
            r_led   <= led_onehot(LED_ERROR);
          end else if (w_word == '0) begin
`ifdef BOOT_CHECKSUM_EN
            r_state <= S_CSUM;
`else
            r_state <= S_READY;
            r_led   <= led_onehot(LED_LOADED);
`endif
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: if (w_word_valid) begin
          r_idx <= r_idx + 1'b1;
`ifdef BOOT_CHECKSUM_EN
          r_csum <= r_csum ^ w_word;
          if (w_last_word) r_state <= S_CSUM;
`else
          if (w_last_word) begin
            r_pw    <= r_n;
            r_state <= S_READY;
            r_led   <= led_onehot(LED_LOADED);
          end
`endif
        end
`ifdef BOOT_CHECKSUM_EN
        S_CSUM: if (w_word_valid) begin
          if (w_word == r_csum) begin
            r_pw    <= r_n;
            r_state <= S_READY;
            r_led   <= led_onehot(LED_LOADED);
          end else begin
            r_state <= S_ERROR;
            r_led   <= led_onehot(LED_ERROR);
          end
        end
`endif
        S_READY: if (START_EXEC || (AUTO_START != 0)) begin
          r_state    <= S_EXEC;
          r_core_rst <= 1'b0;
          r_core_run <= 1'b1;
          r_led      <= led_onehot(LED_EXEC);
        end
        S_EXEC: if (core_halt) begin
          r_state    <= S_HALT;
          r_core_run <= 1'b0;
          r_led      <= led_onehot(LED_HALTED);
        end
        // Restart spends exactly one cycle in HALT with the core held in reset.
        S_HALT: if (r_restart) begin
          r_restart  <= 1'b0;
          r_state    <= S_EXEC;
          r_core_rst <= 1'b0;
          r_core_run <= 1'b1;
          r_led      <= led_onehot(LED_EXEC);
        end else if (RESTART_EXEC) begin
          r_restart  <= 1'b1;
          r_core_rst <= 1'b1;
        end
        S_ERROR: r_state <= S_ERROR;
        default: begin
          r_state    <= S_ERROR;
          r_core_rst <= 1'b1;
          r_core_run <= 1'b0;
          r_led      <= led_onehot(LED_ERROR);
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_boot_sequencer.sv
`default_nettype none
// tb_boot_sequencer: randomized image loads against a queue-based model; a monitor pops expected writes.
// Rev 1.0
module tb_boot_sequencer;
  localparam int AW = 10;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        INITIALIZE = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        START_EXEC = 1'b0;
  logic        RESTART_EXEC = 1'b0;
  logic        core_halt = 1'b0;
  logic        imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] prog_words;
  logic [31:0] sp_init;
  logic        core_rst;
  logic        core_run;
  logic [3:0]  LED;

  boot_sequencer #(.WORD_W(32), .MEM_INST_SIZE(1024), .MEM_SIZE(1024), .AUTO_START(0)) dut (
    .CLK(CLK), .INITIALIZE(INITIALIZE), .rx_data(rx_data), .rx_valid(rx_valid),
    .START_EXEC(START_EXEC), .RESTART_EXEC(RESTART_EXEC), .core_halt(core_halt),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .prog_words(prog_words), .sp_init(sp_init), .core_rst(core_rst),
    .core_run(core_run), .LED(LED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  run_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the expected queue.
  always @(negedge CLK) begin
    wr_t e;
    if (core_run === 1'b1) run_cycles++;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(imem_addr), 64'(e.addr));
        check("write_data", 64'(imem_wdata), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_we", 64'(imem_we), 0);
    check("rst_imem_addr", 64'(imem_addr), 0);
    check("rst_imem_wdata", 64'(imem_wdata), 0);
    check("rst_prog_words", 64'(prog_words), 0);
    check("rst_core_rst", 64'(core_rst), 1);
    check("rst_core_run", 64'(core_run), 0);
    check("rst_led", 64'(LED), 0);
    check("sp_init", 64'(sp_init), 512);
  endtask

  // Reset, then let the one-cycle INITIAL state pass so the next byte is accepted.
  task automatic do_reset();
    INITIALIZE = 1'b1;
    tick();
    INITIALIZE = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    logic [7:0] b;
    for (int i = 3; i >= 0; i--) begin
      b = w[8*i +: 8];
      send_byte(b, int'($urandom_range(0, maxgap)));
    end
  endtask

  // Reference model: header N, N words, optional checksum (XOR of words, corrupted by csum_mask).
  task automatic run_image(input logic [31:0] n, input logic [31:0] words[$], input int maxgap,
                           input logic [31:0] csum_mask);
    wr_t         e;
    logic [31:0] cs;
    bit          len_ok;
    bit          ok;
    cs     = 32'h0;
    len_ok = (n <= 32'd1024);
    ok     = len_ok && (!CSUM_EN || csum_mask == 32'h0);
    send_word(n, maxgap);
    if (len_ok) begin
      foreach (words[i]) begin
        e.addr = AW'(i);
        e.data = words[i];
        exp_q.push_back(e);
        cs = cs ^ words[i];
        send_word(words[i], maxgap);
      end
      if (CSUM_EN) send_word(cs ^ csum_mask, maxgap);
    end
    check("led_before_done", 64'(LED), 0);
    tick();
    check("led_done", 64'(LED), ok ? 64'd1 : 64'd8);
    check("prog_words", 64'(prog_words), ok ? 64'(n) : 64'd0);
    check("core_rst_loaded", 64'(core_rst), 1);
    check("core_run_loaded", 64'(core_run), 0);
    check("writes_pending", 64'(exp_q.size()), 0);
  endtask

  task automatic exec_cycle(input bit with_restart_req, input int n_run);
    START_EXEC   = 1'b1;
    RESTART_EXEC = with_restart_req;
    tick();
    START_EXEC   = 1'b0;
    RESTART_EXEC = 1'b0;
    run_cycles   = 0;
    check("exec_core_run", 64'(core_run), 1);
    check("exec_core_rst", 64'(core_rst), 0);
    check("exec_led", 64'(LED), 2);
    repeat (n_run - 1) tick();
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    check("run_cycles", 64'(run_cycles), 64'(n_run));
    check("halt_core_run", 64'(core_run), 0);
    check("halt_core_rst", 64'(core_rst), 0);
    check("halt_led", 64'(LED), 4);
    START_EXEC = 1'b1;
    repeat (3) tick();
    START_EXEC = 1'b0;
    check("halt_ignores_start", 64'({core_run, LED}), 64'h04);
    RESTART_EXEC = 1'b1;
    tick();
    RESTART_EXEC = 1'b0;
    check("restart_rst_pulse", 64'({core_rst, core_run}), 64'b10);
    tick();
    check("restart_exec", 64'({core_rst, core_run, LED}), 64'b01_0010);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] img[$];
    logic [31:0] rnd[$];
    logic [31:0] n;
    wr_t         e;

    img = '{32'h11223344, 32'hDEADBEEF, 32'h00000001};

    tick();
    check_reset_outputs();
    INITIALIZE = 1'b0;
    tick();

    run_image(32'd3, img, 2, 32'h0);
    exec_cycle(1'b0, 10);

    do_reset();
    run_image(32'd3, img, 0, 32'h0);

    do_reset();
    run_image(32'd1025, rnd, 0, 32'h0);
    send_word($urandom(), 0);
    send_word($urandom(), 1);
    check("error_sticky", 64'({core_rst, LED}), 64'h18);

    do_reset();
    run_image(32'h0001_0003, rnd, 1, 32'h0);

    // Reset in the middle of a load: one word written, one byte of the next.
    do_reset();
    send_word(32'd3, 0);
    e.addr = '0;
    e.data = img[0];
    exp_q.push_back(e);
    send_word(img[0], 0);
    send_byte(img[1][31:24], 0);
    INITIALIZE = 1'b1;
    tick();
    check_reset_outputs();
    check("midload_flush", 64'(exp_q.size()), 0);
    INITIALIZE = 1'b0;
    tick();
    run_image(32'd3, img, 1, 32'h0);

    do_reset();
    run_image(32'd0, rnd, 0, 32'h0);
    exec_cycle(1'b1, 3);

    do_reset();
    for (int i = 0; i < 1024; i++) rnd.push_back($urandom());
    run_image(32'd1024, rnd, 0, 32'h0);

    for (int it = 0; it < 10; it++) begin
      rnd.delete();
      do_reset();
      if ($urandom_range(0, 3) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 32'd1025 + $urandom_range(0, 5000) : 32'h8000_0000 | $urandom_range(0, 8);
      end else begin
        n = $urandom_range(0, 8);
        for (int k = 0; k < int'(n); k++) rnd.push_back($urandom());
      end
      if (CSUM_EN && $urandom_range(0, 2) == 0) begin
        run_image(n, rnd, int'($urandom_range(0, 3)), $urandom() | 32'h1);
      end else begin
        run_image(n, rnd, int'($urandom_range(0, 3)), 32'h0);
        if (n <= 32'd1024) exec_cycle(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
      end
    end

`ifdef BOOT_CHECKSUM_EN
    img = '{32'h0F0F0F0F, 32'hFFFFFFFF};
    do_reset();
    run_image(32'd2, img, 1, 32'h0);
    do_reset();
    run_image(32'd2, img, 0, 32'hF0F0F0F0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
